// File: rtl/register_file.sv
// register_file
//   Architectural integer register file (x0..x31) with per-register rename
//   tags. Committed values from the reorder buffer land in the value array;
//   decoder issue marks a destination as pending on a ROB entry; decoder
//   source queries return either the value or the ROB tag to wait on.
//
//   Parameters
//     ROB_IDX_W  ROB index width (tag width)
//     REG_NUM    architectural register count (index width fixed at 5)
//
//   Ports
//     clk_in                      system clock
//     rst_in                      synchronous active-high reset (dominates rdy_in)
//     rdy_in                      all state frozen when low
//     rob_set_idx/_reg_val/_recorder   commit: rd (0 = none), value, ROB index
//     clear                       ROB flush: drop every pending tag
//     issue_valid/_rd/_rob_idx    issue: mark rd pending on ROB entry
//     query_rs1 -> rs1_val, rs1_dep_valid, rs1_dep   (combinational)
//     query_rs2 -> rs2_val, rs2_dep_valid, rs2_dep   (combinational)
//
//   Optional feature
//     RF_COMMIT_TRACE_EN  when defined, prints every effective commit and
//                         keeps a simulation-only 32-bit commit counter.
module register_file #(
   parameter int ROB_IDX_W = 4,
   parameter int REG_NUM   = 32
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic [4:0]           rob_set_idx,
   input  logic [31:0]          rob_set_reg_val,
   input  logic [ROB_IDX_W-1:0] rob_set_recorder,
   input  logic                 clear,
   input  logic                 issue_valid,
   input  logic [4:0]           issue_rd,
   input  logic [ROB_IDX_W-1:0] issue_rob_idx,
   input  logic [4:0]           query_rs1,
   output logic [31:0]          rs1_val,
   output logic                 rs1_dep_valid,
   output logic [ROB_IDX_W-1:0] rs1_dep,
   input  logic [4:0]           query_rs2,
   output logic [31:0]          rs2_val,
   output logic                 rs2_dep_valid,
   output logic [ROB_IDX_W-1:0] rs2_dep
);

   logic [31:0]          val_reg  [REG_NUM];
   logic                 busy_reg [REG_NUM];
   logic [ROB_IDX_W-1:0] tag_reg  [REG_NUM];

   logic [31:0]          val_next  [REG_NUM];
   logic                 busy_next [REG_NUM];
   logic [ROB_IDX_W-1:0] tag_next  [REG_NUM];

   // ------------------------------------------------------------------
   // Per-register next state
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            // x0 is hardwired: never written, never pending.
            assign val_next[gi]  = '0;
            assign busy_next[gi] = 1'b0;
            assign tag_next[gi]  = '0;
         end else begin : g_arch
            logic commit_hit;
            logic commit_retires;
            logic issue_hit;

            assign commit_hit     = (rob_set_idx == 5'(gi));
            // Only the most recent writer may release the pending state;
            // an older commit with a stale tag leaves the newer tag in place.
            assign commit_retires = commit_hit && busy_reg[gi] &&
                                    (tag_reg[gi] == rob_set_recorder);
            assign issue_hit      = issue_valid && !clear && (issue_rd == 5'(gi));

            // The committed value is always written, even on a flush or when
            // a younger writer is still pending.
            assign val_next[gi]  = commit_hit ? rob_set_reg_val : val_reg[gi];
            // Flush beats issue, issue beats commit-retire.
            assign busy_next[gi] = clear          ? 1'b0 :
                                   issue_hit      ? 1'b1 :
                                   commit_retires ? 1'b0 : busy_reg[gi];
            assign tag_next[gi]  = issue_hit ? issue_rob_idx : tag_reg[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < REG_NUM; i++) begin
            val_reg[i]  <= '0;
            busy_reg[i] <= 1'b0;
            tag_reg[i]  <= '0;
         end
      end else if (rdy_in) begin
         for (int i = 0; i < REG_NUM; i++) begin
            val_reg[i]  <= val_next[i];
            busy_reg[i] <= busy_next[i];
            tag_reg[i]  <= tag_next[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Source queries: combinational, see pre-issue state, with a bypass
   // from a same-cycle commit that retires the pending tag.
   // ------------------------------------------------------------------
   logic [4:0]           q_rs        [2];
   logic [31:0]          q_val       [2];
   logic                 q_dep_valid [2];
   logic [ROB_IDX_W-1:0] q_dep       [2];

   assign q_rs[0] = query_rs1;
   assign q_rs[1] = query_rs2;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         always_comb begin
            q_val[gi]       = '0;
            q_dep_valid[gi] = 1'b0;
            q_dep[gi]       = '0;
            if (q_rs[gi] != 5'd0) begin
               if ((q_rs[gi] == rob_set_idx) && busy_reg[q_rs[gi]] &&
                   (tag_reg[q_rs[gi]] == rob_set_recorder)) begin
                  q_val[gi] = rob_set_reg_val;
               end else if (busy_reg[q_rs[gi]]) begin
                  q_val[gi]       = val_reg[q_rs[gi]];
                  q_dep_valid[gi] = 1'b1;
                  q_dep[gi]       = tag_reg[q_rs[gi]];
               end else begin
                  q_val[gi] = val_reg[q_rs[gi]];
               end
            end
         end
      end
   endgenerate

   assign rs1_val       = q_val[0];
   assign rs1_dep_valid = q_dep_valid[0];
   assign rs1_dep       = q_dep[0];
   assign rs2_val       = q_val[1];
   assign rs2_dep_valid = q_dep_valid[1];
   assign rs2_dep       = q_dep[1];

`ifdef RF_COMMIT_TRACE_EN
   logic [31:0] commit_count_reg;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         commit_count_reg <= '0;
      end else if (rdy_in && (rob_set_idx != 5'd0)) begin
         commit_count_reg <= commit_count_reg + 32'd1;
         $display("RF x%0d <= %h rob=%0d", rob_set_idx, rob_set_reg_val, rob_set_recorder);
      end
   end
`else
`endif

endmodule
